// File: rtl/cymometer_pkg.sv
// Shared constants and encodings for the cymometer BCD conversion path.
package cymometer_pkg;

  localparam int DATA_W = 30;
  localparam int DIGITS = 9;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [DATA_W-1:0] MAX_VAL = 30'd999_999_999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic SRC_FREQ   = 1'b0;
  localparam logic SRC_PERIOD = 1'b1;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
module bcd_dabble_step
  import cymometer_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             bit_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    // NOTE: adj is fully assigned before the loop so no path leaves it holding state (no latch).
    adj = bcd_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

  // The top bit falls off; saturated inputs never need a tenth digit.
  assign bcd_o = {adj[BCD_W-2:0], bit_i};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of a shared sequential binary-to-BCD converter,
// delivering tagged results over a valid/ready handshake.
module bcd_conv_arbiter
  import cymometer_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BCD_W-1:0]  out_bcd,
  output logic              out_src,
  output logic              out_ovf,
  output logic              busy
);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_d;
  logic              src_q;
  logic              ovf_q;
  logic              ptr_q;     // 1 = B wins the next tie
  logic              out_valid_q;
  logic [BCD_W-1:0]  out_bcd_q;
  logic              out_src_q;
  logic              out_ovf_q;

  logic              grant_a;
  logic              grant_b;
  logic [DATA_W-1:0] sel_data;
  logic              sat;

  assign grant_a  = a_valid & (~b_valid | ~ptr_q);
  assign grant_b  = b_valid & (~a_valid |  ptr_q);
  assign a_ready  = (state_q == IDLE) & grant_a;
  assign b_ready  = (state_q == IDLE) & grant_b;
  assign sel_data = grant_b ? b_data : a_data;
  assign sat      = sel_data > MAX_VAL;

  bcd_dabble_step u_step (
    .bcd_i (bcd_q),
    .bit_i (bin_q[DATA_W-1]),
    .bcd_o (bcd_d)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      src_q       <= SRC_FREQ;
      ovf_q       <= 1'b0;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_src_q   <= SRC_FREQ;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_ready | b_ready) begin
            bin_q   <= sat ? MAX_VAL : sel_data;
            ovf_q   <= sat;
            src_q   <= grant_b ? SRC_PERIOD : SRC_FREQ;
            ptr_q   <= ~grant_b;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(DATA_W);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_bcd_q   <= bcd_d;
            out_src_q   <= src_q;
            out_ovf_q   <= ovf_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_src   = out_src_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
